// File: rtl/lcd_arb.sv
// lcd_arb: round-robin arbiter sharing one lcd_ctrl character port among
// NREQ byte-stream message sources. A grant is held for a whole message.
// When ownership changes, a 0xFF clear byte can be injected first. An
// idle watchdog aborts a message whose owner stalls.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   req_val/bits/last   per-requester byte stream (bits packed 8 per source)
//   req_rdy             per-requester accept strobe
//   lcd_rdy             ready from lcd_ctrl
//   lcd_val, lcd_bits   byte stream to lcd_ctrl (bits forced to 0 when idle)
//   owner               current or most recent grantee
//   busy                arbiter is not idle
//   abort               one-cycle pulse when the watchdog kills a message
module lcd_arb #(
   parameter int unsigned NREQ            = 4,
   parameter bit          CLEAR_ON_SWITCH = 1'b1,
   parameter int unsigned TIMEOUT         = 65535
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req_val,
   input  logic [NREQ*8-1:0]       req_bits,
   input  logic [NREQ-1:0]         req_last,
   output logic [NREQ-1:0]         req_rdy,
   input  logic                    lcd_rdy,
   output logic                    lcd_val,
   output logic [7:0]              lcd_bits,
   output logic [$clog2(NREQ)-1:0] owner,
   output logic                    busy,
   output logic                    abort
);

   localparam int unsigned OW      = $clog2(NREQ);
   localparam logic [15:0] TO_LAST = 16'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

   typedef enum logic [1:0] {S_IDLE, S_PREFIX, S_XFER} state_t;

   state_t        state_q, state_d;
   logic [OW-1:0] ptr_q, ptr_d;
   logic [OW-1:0] owner_q, owner_d;
   logic [OW-1:0] last_owner_q, last_owner_d;
   logic          have_last_q, have_last_d;
   logic [15:0]   idle_ctr_q, idle_ctr_d;

   logic          own_val;
   logic          own_last;
   logic [7:0]    own_bits;
   logic [OW-1:0] win_idx;
   int unsigned   rank;
   int unsigned   best_rank;

   // Owner's request lines, selected with constant indices only.
   always_comb begin
      own_val  = 1'b0;
      own_last = 1'b0;
      own_bits = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (owner_q == OW'(i)) begin
            own_val  = req_val[i];
            own_last = req_last[i];
            own_bits = req_bits[i*8 +: 8];
         end
      end
   end

   // Round-robin pick: rank each requester by its distance after ptr and
   // keep the lowest rank, which equals scanning ptr+1 upward with wrap.
   always_comb begin
      rank      = 0;
      best_rank = NREQ;
      win_idx   = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (req_val[i]) begin
            rank = (i + NREQ - 1 - 32'(ptr_q)) % NREQ;
            if (rank < best_rank) begin
               best_rank = rank;
               win_idx   = OW'(i);
            end
         end
      end
   end

   // Handshake outputs are decoded from the state register, so reset drops
   // them immediately; in XFER they pass the owner's lines straight through.
   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      have_last_d  = have_last_q;
      idle_ctr_d   = idle_ctr_q;
      lcd_val      = 1'b0;
      lcd_bits     = '0;
      req_rdy      = '0;
      abort        = 1'b0;

      case (state_q)
         S_IDLE: begin
            idle_ctr_d = '0;
            if (|req_val) begin
               owner_d = win_idx;
               if (CLEAR_ON_SWITCH && (!have_last_q || (win_idx != last_owner_q)))
                  state_d = S_PREFIX;
               else
                  state_d = S_XFER;
            end
         end

         S_PREFIX: begin
            idle_ctr_d = '0;
            lcd_val    = 1'b1;
            lcd_bits   = 8'hFF;
            if (lcd_rdy)
               state_d = S_XFER;
         end

         S_XFER: begin
            lcd_val  = own_val;
            lcd_bits = own_val ? own_bits : 8'h00;
            for (int unsigned i = 0; i < NREQ; i++) begin
               if (owner_q == OW'(i))
                  req_rdy[i] = lcd_rdy;
            end
            if (own_val) begin
               // A valid byte stalled by lcd_rdy is not owner idleness.
               if (lcd_rdy) begin
                  idle_ctr_d = '0;
                  if (own_last) begin
                     ptr_d        = owner_q;
                     last_owner_d = owner_q;
                     have_last_d  = 1'b1;
                     state_d      = S_IDLE;
                  end
               end
            end else if ((TIMEOUT != 0) && (idle_ctr_q == TO_LAST)) begin
               abort       = 1'b1;
               ptr_d       = owner_q;
               have_last_d = 1'b0;
               idle_ctr_d  = '0;
               state_d     = S_IDLE;
            end else begin
               idle_ctr_d = idle_ctr_q + 16'd1;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         ptr_q        <= OW'(NREQ - 1);
         owner_q      <= '0;
         last_owner_q <= '0;
         have_last_q  <= 1'b0;
         idle_ctr_q   <= '0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         have_last_q  <= have_last_d;
         idle_ctr_q   <= idle_ctr_d;
      end
   end

   assign owner = owner_q;
   assign busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_lcd_arb.sv
// tb_lcd_arb: scoreboard bench for lcd_arb (NREQ=4, clear on switch,
// TIMEOUT=8). Each send queues the source's bytes and pushes the bytes
// expected on the lcd port; every lcd handshake pops and compares.
module tb_lcd_arb;

   localparam int unsigned NREQ = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic [NREQ-1:0]   req_val;
   logic [NREQ*8-1:0] req_bits;
   logic [NREQ-1:0]   req_last;
   logic [NREQ-1:0]   req_rdy;
   logic              lcd_rdy;
   logic              lcd_val;
   logic [7:0]        lcd_bits;
   logic [1:0]        owner;
   logic              busy;
   logic              abort;

   lcd_arb #(
      .NREQ           (NREQ),
      .CLEAR_ON_SWITCH(1'b1),
      .TIMEOUT        (8)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .req_val (req_val),
      .req_bits(req_bits),
      .req_last(req_last),
      .req_rdy (req_rdy),
      .lcd_rdy (lcd_rdy),
      .lcd_val (lcd_val),
      .lcd_bits(lcd_bits),
      .owner   (owner),
      .busy    (busy),
      .abort   (abort)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] bits;
      logic [1:0] own;
      logic       last;
      logic       prefix;
   } exp_t;

   exp_t       exp_q[$];
   logic [8:0] src_q[NREQ][$];
   logic [NREQ-1:0] acc;
   logic       rdy_pat[4];
   int         pat_idx;
   int         n_tests;
   int         n_fail;
   int         cyc;
   int         abort_due;
   int         busy_due;
   bit         wd_arm;
   bit         abort_seen;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic send(input int unsigned src, input string s, input bit ff, input bit last_at_end);
      logic lst;
      if (ff)
         exp_q.push_back('{bits: 8'hFF, own: 2'(src), last: 1'b0, prefix: 1'b1});
      for (int i = 0; i < s.len(); i++) begin
         lst = last_at_end && (i == s.len() - 1);
         src_q[src].push_back({lst, 8'(s[i])});
         exp_q.push_back('{bits: 8'(s[i]), own: 2'(src), last: lst, prefix: 1'b0});
      end
   endtask

   task automatic flush();
      exp_q.delete();
      for (int i = 0; i < NREQ; i++) src_q[i].delete();
      acc       = '0;
      abort_due = -1;
      busy_due  = -1;
   endtask

   // Present each source's head byte; pop it if it was accepted last edge.
   task automatic drive();
      for (int i = 0; i < NREQ; i++) begin
         if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
         if (src_q[i].size() > 0) begin
            req_val[i]         = 1'b1;
            req_bits[i*8 +: 8] = src_q[i][0][7:0];
            req_last[i]        = src_q[i][0][8];
         end else begin
            req_val[i]         = 1'b0;
            req_bits[i*8 +: 8] = '0;
            req_last[i]        = 1'b0;
         end
      end
      acc     = '0;
      lcd_rdy = rdy_pat[pat_idx];
      pat_idx = (pat_idx + 1) % 4;
   endtask

   // Sample mid-cycle, then drive new inputs just after the active edge.
   task automatic step();
      logic [NREQ-1:0] oh;
      exp_t e;
      @(negedge clk);
      acc = '0;
      if (!rst) begin
         cyc++;
         oh        = '0;
         oh[owner] = 1'b1;
         chk("rdy_excl", 32'(req_rdy & ~oh), 32'd0);
         chk("abort", 32'(abort), 32'(cyc == abort_due));
         if (abort) abort_seen = 1'b1;
         if (cyc == busy_due) chk("busy_after_last", 32'(busy), 32'd0);
         if (!lcd_val) chk("bits_idle_zero", 32'(lcd_bits), 32'd0);
         if (lcd_val && exp_q.size() > 0) begin
            if (exp_q[0].prefix) chk("prefix_rdy", 32'(req_rdy), 32'd0);
            else                 chk("rdy_follow", 32'(req_rdy[owner]), 32'(lcd_rdy));
         end
         if (lcd_val && lcd_rdy) begin
            if (exp_q.size() == 0) begin
               chk("extra_byte", 32'(lcd_bits), 32'h100);
            end else begin
               e = exp_q.pop_front();
               chk("lcd_bits", 32'(lcd_bits), 32'(e.bits));
               chk("owner", 32'(owner), 32'(e.own));
               abort_due = -1;
               if (e.last) busy_due = cyc + 1;
               if (wd_arm && !e.prefix && !e.last) abort_due = cyc + 8;
            end
         end
         acc = req_val & req_rdy;
      end
      @(posedge clk);
      #1;
      drive();
   endtask

   function automatic bit src_empty();
      bit r = 1'b1;
      for (int i = 0; i < NREQ; i++) if (src_q[i].size() != 0) r = 1'b0;
      return r;
   endfunction

   task automatic wait_idle(input int budget, input string tag);
      bit done = 1'b0;
      for (int k = 0; k < budget && !done; k++) begin
         step();
         if (exp_q.size() == 0 && src_empty() && !busy) done = 1'b1;
      end
      chk({tag, "_drain"}, 32'(done), 32'd1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      flush();
      drive();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_lcd_val", 32'(lcd_val), 32'd0);
      chk("rst_lcd_bits", 32'(lcd_bits), 32'd0);
      chk("rst_req_rdy", 32'(req_rdy), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_abort", 32'(abort), 32'd0);
      chk("rst_owner", 32'(owner), 32'd0);
      rst = 1'b0;
   endtask

   initial begin
      n_tests  = 0;
      n_fail   = 0;
      cyc      = 0;
      pat_idx  = 0;
      wd_arm   = 1'b0;
      abort_seen = 1'b0;
      rdy_pat  = '{1'b1, 1'b1, 1'b1, 1'b1};
      req_val  = '0;
      req_bits = '0;
      req_last = '0;
      lcd_rdy  = 1'b1;
      rst      = 1'b1;
      do_reset();

      // single source, first grant gets a clear
      send(0, "Hi\n", 1'b1, 1'b1);
      wait_idle(40, "single");

      // same owner back to back: no clear bytes
      send(0, "ab", 1'b0, 1'b1);
      send(0, "cd", 1'b0, 1'b1);
      wait_idle(40, "same_owner");

      // contention from reset: grant order 0,1,3,0
      do_reset();
      send(0, "x0", 1'b1, 1'b1);
      send(1, "y1", 1'b1, 1'b1);
      send(3, "z3", 1'b1, 1'b1);
      send(0, "w0", 1'b1, 1'b1);
      wait_idle(80, "rr");

      // backpressure pattern on lcd_rdy
      rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
      pat_idx = 0;
      send(1, "BPq", 1'b1, 1'b1);
      wait_idle(60, "bp");
      rdy_pat = '{1'b1, 1'b1, 1'b1, 1'b1};

      // watchdog: req2 owns last, then stalls after one byte
      send(2, "r2", 1'b1, 1'b1);
      wait_idle(40, "wd_pre");
      wd_arm     = 1'b1;
      abort_seen = 1'b0;
      send(2, "Q", 1'b0, 1'b0);
      wait_idle(40, "wd");
      chk("abort_seen", 32'(abort_seen), 32'd1);
      wd_arm = 1'b0;
      send(2, "ok", 1'b1, 1'b1);
      wait_idle(40, "wd_post");

      // asynchronous reset in the middle of a message
      send(0, "ABCDEFGH", 1'b1, 1'b1);
      for (int k = 0; k < 50 && exp_q.size() > 6; k++) step();
      chk("pre_rst_val", 32'(lcd_val), 32'd1);
      #1;
      rst = 1'b1;
      #1;
      chk("async_lcd_val", 32'(lcd_val), 32'd0);
      chk("async_req_rdy", 32'(req_rdy), 32'd0);
      chk("async_busy", 32'(busy), 32'd0);
      flush();
      drive();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      send(0, "r0", 1'b1, 1'b1);
      send(1, "r1", 1'b1, 1'b1);
      wait_idle(60, "post_rst");

      repeat (3) step();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule

// File: doc/lcd_arb.md
# lcd_arb

Round-robin arbiter that shares the single `lcd_ctrl` character port among `NREQ` message sources, such as a debug monitor, a perf-counter dump and a boot banner. Each source sends a message as a stream of bytes, and the last byte is flagged. A grant is locked for a whole message, so messages never interleave on the display. When ownership changes, the arbiter can first inject a clear byte (0xFF). An idle-watchdog reclaims the port from a source that stalls mid-message.

## Interface
Parameters:
- `NREQ`, default 4: number of requesters, 2..8.
- `CLEAR_ON_SWITCH`, default 1: 1 = inject 0xFF before a message whose owner differs from the previous message's owner.
- `TIMEOUT`, default 65535: number of owner-idle cycles in XFER before the message is aborted; 0 disables the watchdog.

Ports (one clock; reset is asynchronous and active-high):
- `clk`, in, 1: clock.
- `rst`, in, 1: asynchronous active-high reset.
- `req_val`, in, NREQ: requester i has a byte valid.
- `req_bits`, in, NREQ×8: byte from requester i.
- `req_last`, in, NREQ: the byte from requester i is the final byte of its message.
- `req_rdy`, out, NREQ: byte from requester i accepted this cycle when `req_val[i]` is also high.
- `lcd_rdy`, in, 1: `rdy` from `lcd_ctrl`.
- `lcd_val`, out, 1: `val` to `lcd_ctrl`.
- `lcd_bits`, out, 8: `bits` to `lcd_ctrl`.
- `owner`, out, log2(NREQ): current or most recent grantee.
- `busy`, out, 1: state is not IDLE.
- `abort`, out, 1: one-cycle pulse when the watchdog kills a message.

## Operation
- States: IDLE, PREFIX, XFER.
- IDLE:
  - If any `req_val` is high, select the first requester with `req_val` set, scanning from `ptr+1` upward and wrapping modulo NREQ.
  - Register it into `owner`.
  - Go to PREFIX if `CLEAR_ON_SWITCH` is 1 and (`have_last`=0 or the winner ≠ `last_owner`); otherwise go to XFER.
  - No output handshake occurs in IDLE.
- PREFIX:
  - `lcd_val`=1, `lcd_bits`=8'hFF, all `req_rdy`=0.
  - When `lcd_rdy`=1 the clear byte is consumed; go to XFER.
- XFER:
  - `lcd_val` = `req_val[owner]`, `lcd_bits` = `req_bits[owner]`.
  - `req_rdy[owner]` = `lcd_rdy`; all other `req_rdy` bits are 0.
  - This path is combinational pass-through, which is legal because `lcd_rdy` is a registered state decode.
  - A byte transfers when `req_val[owner]`=1 and `lcd_rdy`=1.
  - A transfer with `req_last[owner]`=1 causes: `ptr`←`owner`, `last_owner`←`owner`, `have_last`←1, next state IDLE.
- Watchdog:
  - In XFER, `idle_ctr` (16 bits) clears on every transfer and on entry to XFER.
  - It increments on each cycle with `req_val[owner]`=0.
  - If `TIMEOUT`≠0 and `idle_ctr`==`TIMEOUT`-1 while `req_val[owner]`=0: `abort`=1 for that cycle, `ptr`←`owner`, `have_last`←0 so the next message gets a clear, next state IDLE.
- `lcd_bits` = 0 whenever `lcd_val`=0.
- Arbitration decisions are never taken outside IDLE; requests arriving during PREFIX or XFER wait.
- A requester must hold `req_val`/`req_bits`/`req_last` stable until accepted. The arbiter does not check this.

## Timing
- Reset (asynchronous, any state including mid-message):
  - state IDLE, `ptr`=NREQ-1 so requester 0 wins first, `owner`=0, `have_last`=0, `idle_ctr`=0.
  - Outputs: `lcd_val`=0, `lcd_bits`=0, `req_rdy`=0, `busy`=0, `abort`=0.
  - A partially sent message is dropped. The sender must restart it.
- Grant latency:
  - A request seen in IDLE at cycle t puts the arbiter in PREFIX or XFER at t+1.
  - The earliest data byte accept is t+1, with no prefix and `lcd_rdy`=1.
  - With a prefix, the earliest data byte accept is t+2.
- After the last byte at cycle t, the arbiter is in IDLE at t+1. The next grant is effective at t+2.
- Throughput is bounded by `lcd_ctrl` (one byte per `rdy` window). The arbiter adds no bubbles inside a message.
- `abort` rises in the cycle the timeout condition is met and is low in the next cycle.
- Simultaneous requests in IDLE go to the lowest index at or after `ptr+1` (mod NREQ).
- A requester whose message just finished has the lowest priority at the next arbitration.

## Test plan
- Single source:
  - Stimulus: after reset, req0 sends "Hi\n" with `req_last` on '\n'; `lcd_rdy` held 1.
  - Required: `lcd_bits` sequence FF,48,69,0A; `owner`=0; `busy` falls the cycle after 0A.
- Same owner twice:
  - Stimulus: req0 sends two messages back to back.
  - Required: the second message has no FF prefix.
- Round-robin under contention:
  - Stimulus: req0, req1 and req3 all assert from reset.
  - Required: grant order 0,1,3,0; each message is preceded by FF; no bytes interleave.
- Backpressure:
  - Stimulus: `lcd_rdy` toggles 1,0,0,1 during XFER.
  - Required: `req_rdy[owner]` follows `lcd_rdy` exactly; no byte is dropped or duplicated.
- Watchdog:
  - Stimulus: TIMEOUT=8; req2 sends 1 non-last byte and then drops `req_val`.
  - Required: `abort` pulses exactly 8 cycles after the accept; state returns to IDLE; req2's next message starts with FF.
- Reset mid-message:
  - Stimulus: assert `rst` asynchronously between clock edges during XFER.
  - Required: `lcd_val` and `req_rdy` drop before the next edge; after release, req0 wins first and FF is injected.
